// File: rtl/led_trail_pwm.sv
`default_nettype none
// -----------------------------------------------------------------------------
// led_trail_pwm : renders a one-hot LED position as a PWM "comet trail"
// Rev 1.0
// -----------------------------------------------------------------------------
module led_trail_pwm #(
  parameter int WIDTH     = 8,
  parameter int BW        = 4,
  parameter int DECAY_DIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pos,
  output logic [WIDTH-1:0] led,
  output logic             onehot_err
);

  localparam int            DW        = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [BW-1:0] LMAX      = {BW{1'b1}};
  localparam logic [BW-1:0] PCNT_LAST = LMAX - BW'(1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECAY_DIV - 1);

  logic [WIDTH-1:0] pos_q;
  logic [DW-1:0]    dcnt;
  logic [BW-1:0]    pcnt;
  logic             decay_tick;
  logic             pos_onehot;

  assign decay_tick = (dcnt == DCNT_LAST);

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  assign pos_onehot = (pos_q != '0) && ((pos_q & (pos_q - WIDTH'(1))) == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q      <= WIDTH'(1);
      dcnt       <= '0;
      pcnt       <= '0;
      onehot_err <= 1'b0;
    end else begin
      pos_q      <= pos;
      dcnt       <= decay_tick ? '0 : dcnt + DW'(1);
      pcnt       <= (pcnt == PCNT_LAST) ? '0 : pcnt + BW'(1);
      onehot_err <= onehot_err | ~pos_onehot;
    end
  end

  // PWM period is LMAX cycles so lvl = LMAX gives a solid-on LED.
  for (genvar i = 0; i < WIDTH; i++) begin : g_led
    logic [BW-1:0] lvl;
    logic          led_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lvl   <= '0;
        led_q <= 1'b0;
      end else begin
        if (pos_q[i]) begin
          lvl <= LMAX;
        end else if (decay_tick && (lvl != '0)) begin
          lvl <= lvl - BW'(1);
        end
        led_q <= (lvl > pcnt);
      end
    end

    assign led[i] = led_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_led_trail_pwm : directed bench for led_trail_pwm at default parameters
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_led_trail_pwm;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pos;
  logic [7:0] led;
  logic       onehot_err;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  int win [0:19];
  int exp_win [0:13] = '{14, 15, 14, 13, 12, 11, 10, 9, 8, 8, 7, 6, 5, 4};
  int led2_off;
  int led0_late_on;
  int led0_at256;
  int reload_miss;

  always #5 clk = ~clk;

  led_trail_pwm #(
    .WIDTH     (8),
    .BW        (4),
    .DECAY_DIV (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pos        (pos),
    .led        (led),
    .onehot_err (onehot_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  // Called at a falling edge; reset drops halfway between rising edges.
  task automatic apply_reset(input logic [7:0] p);
    reset = 1'b0;
    pos   = p;
    #1;
    check("rst_async_led", led, 8'h00);
    check("rst_async_err", onehot_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_led", led, 8'h00);
    reset = 1'b1;
    n     = 0;
  endtask

  task automatic err_run(input logic [7:0] bad);
    int cnt;
    apply_reset(8'h01);
    repeat (5) step();
    pos = bad;
    step();
    check("err_edge1", onehot_err, 1'b0);
    pos = 8'h01;
    step();
    check("err_edge2", onehot_err, 1'b1);
    cnt = 0;
    repeat (20) begin
      step();
      if (onehot_err !== 1'b1) cnt++;
    end
    check("err_sticky", cnt, 0);
  endtask

  // 01 -> 02 -> 04 for 16 cycles each; optionally return to 01 at reload_at.
  task automatic trail_run(input int reload_at);
    apply_reset(8'h01);
    foreach (win[j]) win[j] = 0;
    led2_off     = 0;
    led0_late_on = 0;
    led0_at256   = 0;
    reload_miss  = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (led[0]) win[(n - 1) / 15]++;
      if (n >= 35 && n <= 220 && !led[2]) led2_off++;
      if (n >= 257 && led[0]) led0_late_on++;
      if (n == 256 && led[0]) led0_at256 = 1;
      if (n >= 225 && n <= 240 && !led[0]) reload_miss++;
      if (n == 16) pos = 8'h02;
      if (n == 32) pos = 8'h04;
      if (n == reload_at) pos = 8'h01;
    end
  endtask

  initial begin
    int cnt_led;
    int cnt_err;

    reset = 1'b1;
    pos   = 8'h01;
    n     = 0;
    @(negedge clk);

    err_run(8'h03);
    err_run(8'h00);

    // Release with pos = 01: led[0] from the second edge, solid on.
    apply_reset(8'h01);
    step();
    check("rel_edge1_led", led, 8'h00);
    step();
    check("rel_edge2_led", led, 8'h01);
    cnt_led = 0;
    repeat (28) begin
      step();
      if (led !== 8'h01) cnt_led++;
    end
    check("rel_led_steady", cnt_led, 0);

    // Steady position 10; bit 0 is still decaying from the reset pattern.
    apply_reset(8'h10);
    step();
    step();
    cnt_led = 0;
    cnt_err = 0;
    repeat (100) begin
      step();
      if ((led & 8'hFE) !== 8'h10) cnt_led++;
      if (onehot_err !== 1'b0) cnt_err++;
    end
    check("steady_led", cnt_led, 0);
    check("steady_err", cnt_err, 0);

    trail_run(0);
    for (int j = 0; j < 14; j++) begin
      check($sformatf("trail_win%0d", j), win[j], exp_win[j]);
    end
    check("trail_led2_on", led2_off, 0);
    check("trail_led0_last", led0_at256, 1);
    check("trail_led0_dark", led0_late_on, 0);
    check("trail_err", onehot_err, 1'b0);

    trail_run(222);
    check("reload_full", reload_miss, 0);
    check("reload_win12", win[12], 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
